// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: single-outstanding load/store unit driving a 64-word data memory.
// Define LSU_SUBWORD_EN to build byte/half loads and read-modify-write sub-word stores.
module lsu_dmem_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic        accept;
  logic        size_err;
  logic        req_err;
  logic        we_q;
  logic        err_q;
  logic [29:0] widx_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] ld_data;
  logic [31:0] st_data;

  assign accept = req_valid && req_ready;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  off_q;
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign size_err = (req_size == 2'd3)
                 || (req_size == 2'd1 && req_addr[0])
                 || (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  // Sub-request fields used by the extract and merge paths
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q <= 2'd0;
      sgn_q  <= 1'b0;
      off_q  <= 2'd0;
    end else if (accept) begin
      size_q <= req_size;
      sgn_q  <= req_signed;
      off_q  <= req_addr[1:0];
    end
  end

  assign sh   = size_q[0] ? {off_q[1], 4'b0000}
                          : {off_q, 3'b000};
  assign mask = (size_q[0] ? 32'h0000_FFFF
                           : 32'h0000_00FF) << sh;
  assign ld_b = 8'(word_q >> sh);
  assign ld_h = off_q[1] ? word_q[31:16]
                         : word_q[15:0];

  // Load extraction and store merge
  always_comb begin
    ld_data = word_q;
    st_data = wdata_q;
    unique case (1'b1)
      (size_q == 2'd0):
        ld_data = {{24{sgn_q & ld_b[7]}}, ld_b};
      (size_q == 2'd1):
        ld_data = {{16{sgn_q & ld_h[15]}}, ld_h};
      default: ld_data = word_q;
    endcase
    if (size_q != 2'd2) begin
      st_data = (word_q & ~mask)
              | ((wdata_q << sh) & mask);
    end
  end
`else
  logic unused_req;

  assign unused_req = req_signed;
  assign size_err   = (req_size != 2'd2)
                   || (req_addr[1:0] != 2'd0);
  assign ld_data    = word_q;
  assign st_data    = wdata_q;
`endif

  assign req_err = (req_addr[31:8] != 24'd0) || size_err;

  // State register, aborts to IDLE on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and memory read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      widx_q  <= 30'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        widx_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
      end
      if (state_q == RD) begin
        word_q <= mem_rdata;
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD;
`ifdef LSU_SUBWORD_EN
          end else if (req_size != 2'd2) begin
            state_d = RD;
`endif
          end else begin
            state_d = WR;
          end
        end
      end
`ifdef LSU_SUBWORD_EN
      RD:      state_d = we_q ? WR : RESP;
`else
      RD:      state_d = RESP;
`endif
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory and response outputs decoded from state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    unique case (1'b1)
      (state_q == IDLE): req_ready = !rst;
      (state_q == RD): begin
        mem_read = 1'b1;
        mem_addr = {2'b00, widx_q};
      end
      (state_q == WR): begin
        mem_write = 1'b1;
        mem_addr  = {2'b00, widx_q};
        mem_wdata = st_data;
      end
      (state_q == RESP): begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) begin
          resp_rdata = ld_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: scoreboard bench with a word-array memory and a
// behavioural LSU reference model.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_dmem_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          nrd;
    int          nwr;
    logic [5:0]  widx;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          nrd_seen = 0;
  int          nwr_seen = 0;
  int          last_t = 0;
  int          last_lat = 0;
  bit          prev_held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
  end

  assign mem_rdata = mem_read ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic model(input bit we, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic err,
                       output int lat, output int nrd, output int nwr);
    logic [31:0] w, v, m;
    int s;
    bit sub_ok;
`ifdef LSU_SUBWORD_EN
    sub_ok = 1;
`else
    sub_ok = 0;
`endif
    w   = ref_mem[a[7:2]];
    rd  = 0;
    err = (a > 32'd255) || sz == 3 || (sz == 1 && a[0])
       || (sz == 2 && a[1:0] != 0) || (!sub_ok && sz < 2);
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    s = (sz == 0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
    if (!we) begin
      lat = 2; nrd = 1; nwr = 0;
      if (sz == 0) begin
        v = (w >> s) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = (w >> s) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      rd = v;
    end else if (sz == 2) begin
      lat = 2; nrd = 0; nwr = 1;
      ref_mem[a[7:2]] = wd;
    end else begin
      lat = 3; nrd = 1; nwr = 1;
      m = ((sz == 0) ? 32'hFF : 32'hFFFF) << s;
      ref_mem[a[7:2]] = (w & ~m) | ((wd << s) & m);
    end
  endtask

  task automatic issue(input bit we, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd,
                       input bit push, input bit hold);
    exp_t e;
    int n, t, lat, nr, nw;
    logic [31:0] rd;
    logic er;
    req_valid  = 1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: ready %b expected 1", req_ready);
      req_valid = 0;
      prev_held = 0;
      return;
    end
    t = cyc;
    if (push) begin
      model(we, sz, sg, a, wd, rd, er, lat, nr, nw);
      e.rdata = rd; e.err = er; e.cyc = t + lat;
      e.nrd = nr; e.nwr = nw; e.widx = a[7:2];
      q.push_back(e);
      if (prev_held) chk("b2b_accept_cycle", t, last_t + last_lat + 1);
      last_t = t;
      last_lat = lat;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
    prev_held = hold && push;
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      nrd_seen = 0;
      nwr_seen = 0;
    end else begin
      if (mem_read && mem_write) chk("rd_wr_exclusive", 1, 0);
      if (mem_read || mem_write || resp_valid)
        chk("ready_low_busy", {31'd0, req_ready}, 0);
      if (mem_read || mem_write) begin
        if (mem_read) nrd_seen++;
        if (mem_write) nwr_seen++;
        if (q.size() > 0)
          chk("mem_addr", mem_addr, {26'd0, q[0].widx});
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {31'd0, resp_valid}, 0);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          chk("resp_cycle", cyc, e.cyc);
          chk("mem_reads", nrd_seen, e.nrd);
          chk("mem_writes", nwr_seen, e.nwr);
        end
        nrd_seen = 0;
        nwr_seen = 0;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        tests++; fails++;
        $display("FAIL resp_timeout: no resp by cycle %0d", e.cyc);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int n;
    rst = 1; req_valid = 0; req_we = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0;
    #3;
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_mem_read", {31'd0, mem_read}, 0);
    chk("rst_mem_write", {31'd0, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 1);
    chk("post_rst_resp", {31'd0, resp_valid}, 0);

    for (int i = 0; i < 64; i++)
      issue(1, 2, 0, i * 4, $urandom, 1, i[0]);

    issue(1, 2, 0, 32'h44, 32'hDEADBEEF, 1, 0);
    issue(0, 2, 0, 32'h44, 0, 1, 0);
    issue(1, 2, 0, 32'h3C, 32'h0000_80F1, 1, 0);
    issue(1, 2, 0, 32'h40, 32'h1122_3344, 1, 0);
    issue(0, 0, 1, 32'h3C, 0, 1, 0);
    issue(0, 1, 0, 32'h3C, 0, 1, 0);
    issue(0, 1, 1, 32'h3C, 0, 1, 0);
    issue(1, 0, 0, 32'h42, 32'h0000_00AA, 1, 0);
    issue(0, 2, 0, 32'h40, 0, 1, 0);
    issue(0, 2, 0, 32'h46, 0, 1, 0);
    issue(1, 1, 0, 32'h41, 32'h1234, 1, 0);
    issue(0, 2, 0, 32'h100, 0, 1, 0);
    issue(0, 3, 0, 32'h10, 0, 1, 1);
    issue(0, 2, 0, 32'h3C, 0, 1, 1);
    issue(1, 2, 0, 32'h08, 32'h0BAD_F00D, 1, 1);
    issue(0, 2, 0, 32'h08, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
`ifdef LSU_SUBWORD_EN
    chk("rmw_word_0x40", mem[16], 32'h11AA_3344);
`else
    chk("rmw_word_0x40", mem[16], 32'h1122_3344);
`endif
    chk("store_word_0x44", mem[17], 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2) a = a & ~32'h3;
        if (sz == 1) a = a & ~32'h1;
      end
      if ($urandom_range(0, 19) == 0)
        a = a | (32'h100 << $urandom_range(0, 23));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom, 1, 1'($urandom_range(0, 1)));
    end
    req_valid = 0;
    prev_held = 0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;

    issue(1, 2, 0, 32'h80, ~ref_mem[32], 0, 0);
    chk("rst_midop_in_wr", {31'd0, mem_write}, 1);
    rst = 1;
    #1;
    chk("rst_midop_write", {31'd0, mem_write}, 0);
    chk("rst_midop_read", {31'd0, mem_read}, 0);
    chk("rst_midop_addr", mem_addr, 0);
    chk("rst_midop_wdata", mem_wdata, 0);
    chk("rst_midop_resp", {31'd0, resp_valid}, 0);
    chk("rst_midop_ready", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_midop_word", mem[32], ref_mem[32]);
    issue(0, 2, 0, 32'h80, 0, 1, 0);
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++)
      chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL pending_resp: %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
